// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master is the loader side; slave is the byte source / memory side.
interface imem_loader_if;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        WE;
   logic [31:0] WAddr;
   logic [31:0] WData;

   modport master (
      input  ByteIn,
      input  ByteValid,
      output ByteReady,
      output WE,
      output WAddr,
      output WData
   );

   modport slave (
      output ByteIn,
      output ByteValid,
      input  ByteReady,
      input  WE,
      input  WAddr,
      input  WData
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a framed byte stream (length, LE words,
// XOR checksum), writes each word to consecutive addresses and releases CPU reset on success.
module imem_loader #(
   parameter int unsigned DEPTH     = 128,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          Start,
   imem_loader_if.master bus,
   output logic          Busy,
   output logic          Done,
   output logic          Err,
   output logic          CPU_RESET
);

   typedef enum logic [2:0] {
      StIdle, StLen0, StLen1, StData, StCsum, StDone, StErr
   } state_e;

   state_e      state_q, state_d;
   logic        accept;
   logic        enter_len0;
   logic        last_word;
   logic [15:0] n_rx;
   logic [15:0] len_q;
   logic [15:0] idx_q;
   logic [1:0]  lane_q;
   logic [7:0]  xor_q;
   logic [23:0] part_q;
   logic        we_q;
   logic [31:0] waddr_q;
   logic [31:0] wdata_q;

   assign accept     = bus.ByteValid && bus.ByteReady;
   assign n_rx       = {bus.ByteIn, len_q[7:0]};
   assign last_word  = (lane_q == 2'd3) && (idx_q == len_q - 16'd1);
   assign enter_len0 = (state_d == StLen0) && (state_q != StLen0);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone, StErr: begin
            if (Start) state_d = StLen0;
         end
         StLen0: begin
            if (accept) state_d = StLen1;
         end
         StLen1: begin
            if (accept) begin
               if (32'(n_rx) > DEPTH) state_d = StErr;
               else if (n_rx == 16'd0) state_d = StCsum;
               else state_d = StData;
            end
         end
         StData: begin
            if (accept && last_word) state_d = StCsum;
         end
         StCsum: begin
            if (accept) state_d = (bus.ByteIn == xor_q) ? StDone : StErr;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.ByteReady = 1'b0;
      Busy          = 1'b0;
      Done          = 1'b0;
      Err           = 1'b0;
      CPU_RESET     = 1'b1;
      case (state_q)
         StLen0, StLen1, StData, StCsum: begin
            bus.ByteReady = 1'b1;
            Busy          = 1'b1;
         end
         StDone: begin
            Done      = 1'b1;
            CPU_RESET = 1'b0;
         end
         StErr:   Err = 1'b1;
         default: ;
      endcase
      bus.WE    = we_q;
      bus.WAddr = waddr_q;
      bus.WData = wdata_q;
   end

   // Bytes 0..2 of a word shift down into part_q; byte 3 completes the word and fires the write.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         len_q   <= 16'd0;
         idx_q   <= 16'd0;
         lane_q  <= 2'd0;
         xor_q   <= 8'd0;
         part_q  <= 24'd0;
         we_q    <= 1'b0;
         waddr_q <= BASE_ADDR;
         wdata_q <= 32'd0;
      end else begin
         we_q <= 1'b0;
         if (enter_len0) begin
            xor_q  <= 8'd0;
            idx_q  <= 16'd0;
            lane_q <= 2'd0;
         end else if (accept) begin
            xor_q <= xor_q ^ bus.ByteIn;
            case (state_q)
               StLen0: len_q[7:0]  <= bus.ByteIn;
               StLen1: len_q[15:8] <= bus.ByteIn;
               StData: begin
                  lane_q <= lane_q + 2'd1;
                  if (lane_q == 2'd3) begin
                     we_q    <= 1'b1;
                     waddr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
                     wdata_q <= {bus.ByteIn, part_q};
                     idx_q   <= idx_q + 16'd1;
                  end else begin
                     part_q <= {bus.ByteIn, part_q[23:8]};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frame table, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_imem_loader;
   localparam int unsigned DEPTH = 128;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   logic Start = 1'b0;
   logic Busy, Done, Err, CPU_RESET;

   imem_loader_if bus ();

   imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .Start    (Start),
      .bus      (bus),
      .Busy     (Busy),
      .Done     (Done),
      .Err      (Err),
      .CPU_RESET(CPU_RESET)
   );

   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;
   logic [63:0] wq[$];

   always @(negedge CLK) if (bus.WE === 1'b1) wq.push_back({bus.WAddr, bus.WData});

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   typedef struct packed {
      logic [3:0]         nb;
      logic [0:10][7:0]   b;
      logic               gaps;
      logic [3:0]         mid;    // byte index at which Start is pulsed; 15 = never
      logic               exp_done;
      logic               exp_err;
      logic [1:0]         exp_nw;
      logic [0:1][31:0]   exp_w;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      while (bus.ByteReady !== 1'b1 && t < 16) begin
         @(negedge CLK);
         t++;
      end
      if (bus.ByteReady !== 1'b1) chk("ready_timeout", {31'd0, bus.ByteReady}, 32'd1);
      bus.ByteIn    = b;
      bus.ByteValid = 1'b1;
      @(negedge CLK);
      bus.ByteValid = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] fb[$], input bit gaps, input int mid);
      wq.delete();
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      chk("start_ready", {31'd0, bus.ByteReady}, 32'd1);
      chk("start_clears_flags", {30'd0, Done, Err}, 32'd0);
      chk("start_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
      for (int i = 0; i < fb.size(); i++) begin
         if (i == mid) Start = 1'b1;
         send_byte(fb[i]);
         Start = 1'b0;
         if (gaps && i != fb.size() - 1) @(negedge CLK);
      end
   endtask

   task automatic check_result(input string name, input bit d, input bit e,
                               input logic [63:0] ew[$]);
      chk({name, "_done"}, {31'd0, Done}, {31'd0, d});
      chk({name, "_err"}, {31'd0, Err}, {31'd0, e});
      chk({name, "_cpu_reset"}, {31'd0, CPU_RESET}, {31'd0, !d});
      chk({name, "_idle"}, {30'd0, Busy, bus.ByteReady}, 32'd0);
      chk({name, "_nwrites"}, wq.size(), ew.size());
      for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
         chk({name, "_waddr"}, wq[i][63:32], ew[i][63:32]);
         chk({name, "_wdata"}, wq[i][31:0], ew[i][31:0]);
      end
   endtask

   // Reference: decode the frame from its own rules, independent of any cycle behaviour.
   task automatic model(input logic [7:0] fb[$], output bit d, output bit e,
                        output logic [63:0] ew[$]);
      int n;
      logic [7:0] x;
      ew.delete();
      n = {fb[1], fb[0]};
      if (n > DEPTH) begin
         d = 1'b0;
         e = 1'b1;
         return;
      end
      x = 8'd0;
      for (int i = 0; i < fb.size() - 1; i++) x ^= fb[i];
      for (int i = 0; i < n; i++)
         ew.push_back({BASE + 32'(4 * i), fb[2+4*i+3], fb[2+4*i+2], fb[2+4*i+1], fb[2+4*i]});
      d = (x == fb[fb.size()-1]);
      e = !d;
   endtask

   localparam logic [87:0] NOMINAL = {8'h02, 8'h00, 8'h04, 8'h12, 8'h9F, 8'hE5,
                                      8'h04, 8'h92, 8'h9F, 8'hE5, 8'h82};
   localparam logic [87:0] BADSUM  = {8'h02, 8'h00, 8'h04, 8'h12, 8'h9F, 8'hE5,
                                      8'h04, 8'h92, 8'h9F, 8'hE5, 8'h83};

   initial begin
      logic [7:0]  fb[$];
      logic [63:0] ew[$];
      bit          d, e;

      bus.ByteIn    = 8'd0;
      bus.ByteValid = 1'b0;

      #3;
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_ready", {31'd0, bus.ByteReady}, 32'd0);
      chk("rst_we", {31'd0, bus.WE}, 32'd0);
      chk("rst_waddr", bus.WAddr, BASE);
      chk("rst_wdata", bus.WData, 32'd0);
      chk("rst_flags", {30'd0, Done, Err}, 32'd0);
      chk("rst_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);

      vecs[0] = '{nb: 11, b: NOMINAL, gaps: 0, mid: 15, exp_done: 1, exp_err: 0,
                  exp_nw: 2, exp_w: {32'hE59F1204, 32'hE59F9204}};
      vecs[1] = '{nb: 3, b: 88'h0, gaps: 0, mid: 15, exp_done: 1, exp_err: 0,
                  exp_nw: 0, exp_w: 64'h0};
      vecs[2] = '{nb: 2, b: {8'h81, 80'h0}, gaps: 0, mid: 15, exp_done: 0, exp_err: 1,
                  exp_nw: 0, exp_w: 64'h0};
      vecs[3] = '{nb: 11, b: BADSUM, gaps: 0, mid: 15, exp_done: 0, exp_err: 1,
                  exp_nw: 2, exp_w: {32'hE59F1204, 32'hE59F9204}};
      vecs[4] = '{nb: 11, b: NOMINAL, gaps: 1, mid: 15, exp_done: 1, exp_err: 0,
                  exp_nw: 2, exp_w: {32'hE59F1204, 32'hE59F9204}};
      vecs[5] = '{nb: 11, b: NOMINAL, gaps: 0, mid: 6, exp_done: 1, exp_err: 0,
                  exp_nw: 2, exp_w: {32'hE59F1204, 32'hE59F9204}};

      for (int v = 0; v < 6; v++) begin
         fb.delete();
         ew.delete();
         for (int j = 0; j < vecs[v].nb; j++) fb.push_back(vecs[v].b[j]);
         for (int j = 0; j < vecs[v].exp_nw; j++)
            ew.push_back({BASE + 32'(4 * j), vecs[v].exp_w[j]});
         run_frame(fb, vecs[v].gaps, int'(vecs[v].mid));
         check_result($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, ew);
      end

      // Reset after the second data byte: partial word must be discarded.
      fb.delete();
      for (int j = 0; j < 4; j++) fb.push_back(NOMINAL[87-8*j -: 8]);
      run_frame(fb, 1'b0, -1);
      #2 RESET = 1'b1;
      #1;
      chk("midrst_we", {31'd0, bus.WE}, 32'd0);
      chk("midrst_busy", {31'd0, Busy}, 32'd0);
      chk("midrst_ready", {31'd0, bus.ByteReady}, 32'd0);
      chk("midrst_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
      chk("midrst_waddr", bus.WAddr, BASE);
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      fb.delete();
      for (int j = 0; j < 11; j++) fb.push_back(NOMINAL[87-8*j -: 8]);
      model(fb, d, e, ew);
      run_frame(fb, 1'b0, -1);
      check_result("after_rst", d, e, ew);

      // Random frames, including the N = DEPTH and N = DEPTH+1 boundaries.
      for (int k = 0; k < 10; k++) begin
         int n;
         logic [7:0] x, b;
         n = (k == 0) ? DEPTH : (k == 1) ? DEPTH + 1 : $urandom_range(0, 12);
         fb.delete();
         fb.push_back(n[7:0]);
         fb.push_back(n[15:8]);
         if (n <= DEPTH) begin
            x = n[7:0] ^ n[15:8];
            for (int j = 0; j < 4 * n; j++) begin
               b = 8'($urandom);
               fb.push_back(b);
               x ^= b;
            end
            if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
            fb.push_back(x);
         end
         model(fb, d, e, ew);
         run_frame(fb, bit'($urandom_range(0, 1)), -1);
         check_result($sformatf("rand%0d", k), d, e, ew);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's 128-word instruction memory. It receives a framed byte stream (length, little-endian instruction words, checksum) over a valid/ready byte interface and assembles each group of four bytes into a 32-bit word. It issues one write per word to the instruction-memory write port at consecutive word-aligned byte addresses. It holds the CPU in reset until a frame loads cleanly.

## Interface
Parameters:
- DEPTH, 128: instruction memory size in 32-bit words; frames longer than this are rejected.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be word-aligned.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request to begin receiving a frame.
- ByteIn  in  8  stream byte.
- ByteValid  in  1  ByteIn is valid this cycle.
- ByteReady  out  1  loader accepts a byte this cycle.
- WE  out  1  instruction-memory write strobe; one cycle per word.
- WAddr  out  32  byte address of the write; always word-aligned.
- WData  out  32  instruction word to write.
- Busy  out  1  frame in progress.
- Done  out  1  last frame loaded and checksum matched.
- Err  out  1  last frame rejected (length > DEPTH or checksum mismatch).
- CPU_RESET  out  1  reset hold to the processor core.

## Operation
- Frame format: L0, L1 (16-bit word count N = {L1,L0}), then 4·N data bytes, then C.
  - Each word is sent LSB byte first: word = {b3,b2,b1,b0}.
  - C = XOR of all preceding frame bytes, including L0 and L1.
- A byte is accepted on a rising edge where ByteValid && ByteReady.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR: Start → LEN0. Busy=0, ByteReady=0.
  - LEN0: accept byte → LEN1.
  - LEN1: accept byte, then branch on N:
    - N > DEPTH → ERR.
    - N = 0 → CSUM.
    - otherwise → DATA.
  - DATA: accept bytes; a 2-bit byte counter shifts each byte into its lane.
    - On the 4th byte, WE/WAddr/WData are registered for the next cycle and the word index increments.
    - After word N-1 → CSUM.
  - CSUM: accept byte; it equals the running XOR → DONE, otherwise → ERR.
- ByteReady = 1 exactly in LEN0, LEN1, DATA, CSUM. Busy is the same set.
- WAddr = BASE_ADDR + 4·index, with index counting from 0 within the frame.
- The running XOR and the index clear on entry to LEN0.
- Start is ignored while Busy.
- Start from DONE or ERR clears Done and Err and begins a new frame.
- CPU_RESET:
  - 1 in IDLE, LEN0..CSUM, and ERR.
  - 0 only in DONE.
  - Deasserts on the cycle Done rises.
- A checksum failure does not undo writes already issued; memory contents are then undefined and CPU_RESET stays asserted.

## Timing
- Reset values: state IDLE, ByteReady=0, WE=0, WAddr=BASE_ADDR, WData=0, Busy=0, Done=0, Err=0, CPU_RESET=1.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). A pending write is dropped. Partial words are discarded.
- Start at edge t → ByteReady=1 from cycle t+1.
- Write latency: WE is high for exactly one cycle, the cycle after the edge that accepts byte b3. WAddr/WData are valid while WE=1.
- Full rate: one byte per cycle, so WE is high at most every 4th cycle. Gaps in ByteValid stall the FSM without loss.
- Done or Err is asserted the cycle after C is accepted (or after L1 when N > DEPTH), and holds until Start or RESET.
- Counter widths: byte lane 2 bits; word index 16 bits (compared against N); length 16 bits. No wrap occurs because N ≤ DEPTH.

## Test plan
- Nominal load: Start, then bytes 02 00 04 12 9F E5 04 92 9F E5 82 back-to-back.
  - Required: WE at 0x0 with E59F1204, WE at 0x4 with E59F9204.
  - Then Done=1, Err=0, CPU_RESET=0.
- Empty frame: bytes 00 00 00.
  - Required: no WE; Done=1 the cycle after the 3rd byte.
- Oversize: bytes 81 00 (N=129).
  - Required: Err=1 after the 2nd byte, no WE, ByteReady=0, CPU_RESET=1.
- Bad checksum: the nominal frame with C=83.
  - Required: both writes occur; Err=1, Done=0, CPU_RESET=1.
- Backpressure and restart:
  - Nominal frame with ByteValid toggled 1/0 each cycle → identical writes and Done.
  - Start pulsed mid-frame is ignored.
  - Start in DONE clears Done and accepts a new frame.
- Reset mid-word: RESET asserted after the 2nd data byte.
  - Required: immediately WE=0, Busy=0, CPU_RESET=1.
  - After release, a fresh nominal frame loads correctly starting at address 0x0.
